// File: rtl/synth_pkg.sv
// Shared widths, types and state encodings for the trumpet sample player.
package synth_pkg;

  localparam int SAMPLE_W   = 24;
  localparam int ROM_ADDR_W = 17;
  localparam int FRAC_W     = 8;
  localparam int PHASE_W    = ROM_ADDR_W + FRAC_W;
  localparam int GAIN_W     = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [PHASE_W-1:0]         phase_t;
  typedef logic [ROM_ADDR_W-1:0]      rom_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    RELEASE
  } play_state_e;

  typedef enum logic [1:0] {
    F_WAIT,
    F_ADDR,
    F_DATA
  } fetch_state_e;

endpackage

// File: rtl/sample_player_if.sv
// Bundle of note control, ROM and audio-out signals around the sample player.
interface sample_player_if;
  import synth_pkg::*;

  logic               note_on;
  logic               note_off;
  phase_t             step;
  logic               loop_en;
  logic [GAIN_W-1:0]  gain;
  logic               sample_req;
  rom_addr_t          rom_addr;
  sample_t            rom_data;
  sample_t            sample_out;
  logic               sample_valid;
  logic               busy;
  logic               overrun;

  // The player itself
  modport slave (
    input  note_on, note_off, step, loop_en, gain, sample_req, rom_data,
    output rom_addr, sample_out, sample_valid, busy, overrun
  );

  // Whoever drives notes/requests and provides the ROM
  modport master (
    output note_on, note_off, step, loop_en, gain, sample_req, rom_data,
    input  rom_addr, sample_out, sample_valid, busy, overrun
  );

endinterface

// File: rtl/sample_phase_acc.sv
// Fixed-point playback phase: accumulates the pitch step and wraps or ends
// when the integer part runs past the last ROM index.
module sample_phase_acc
  import synth_pkg::*;
#(
  parameter int LAST_ADDR  = 48000,
  parameter int LOOP_START = 24000
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      clear,
  input  logic      advance,
  input  phase_t    step,
  input  logic      loop_en,
  output rom_addr_t int_addr,
  output logic      end_hit
);

  localparam logic [ROM_ADDR_W:0] LAST_A   = (ROM_ADDR_W+1)'(LAST_ADDR);
  localparam logic [ROM_ADDR_W:0] WRAP_OFS = (ROM_ADDR_W+1)'(LAST_ADDR + 1 - LOOP_START);

  phase_t                phase;
  logic [PHASE_W:0]      sum;
  logic [ROM_ADDR_W:0]   sum_int;
  logic                  past_end;
  rom_addr_t             wrap_int;

  // Next phase candidate, end detection and the loop-wrapped integer part
  always_comb begin
    sum      = {1'b0, phase} + {1'b0, step};
    sum_int  = sum[PHASE_W:FRAC_W];
    past_end = (sum_int > LAST_A);
    wrap_int = ROM_ADDR_W'(sum_int - WRAP_OFS);
    end_hit  = advance && past_end && !loop_en;
    int_addr = phase[PHASE_W-1:FRAC_W];
  end

  // Phase register: cleared on (re)trigger, stepped once per delivered sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (advance) begin
      if (past_end) begin
        if (loop_en) phase <= {wrap_int, sum[FRAC_W-1:0]};
        else         phase <= '0;
      end else begin
        phase <= sum[PHASE_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sample_player.sv
// Note-driven playback engine: fetches pitch-scaled ROM samples on request,
// applies the gain/release envelope and hands one sample per request out.
module sample_player
  import synth_pkg::*;
#(
  parameter int LAST_ADDR  = 48000,
  parameter int LOOP_START = 24000,
  parameter int REL_STEP   = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  sample_player_if.slave  bus
);

  localparam logic [GAIN_W-1:0] REL = GAIN_W'(REL_STEP);

  play_state_e              play_state, play_next;
  fetch_state_e             fetch_state, fetch_next;
  logic [GAIN_W-1:0]        env;
  logic [GAIN_W-1:0]        fetch_env;
  logic                     fetch_silent;
  logic                     skip_adv;
  logic                     req_accept;
  logic                     sample_done;
  logic                     upd;
  logic                     advance;
  logic                     end_hit;
  rom_addr_t                int_addr;
  logic signed [SAMPLE_W+GAIN_W:0] product;
  sample_t                  scaled;

  // A retrigger during a fetch must not disturb the fresh phase/env, so the
  // per-sample update is skipped for that fetch.
  always_comb begin
    req_accept  = (fetch_state == F_WAIT) && bus.sample_req;
    sample_done = (fetch_state == F_DATA);
    upd         = sample_done && !bus.note_on && !skip_adv;
    advance     = upd && (play_state != IDLE);
    product     = (SAMPLE_W+GAIN_W+1)'(bus.rom_data) *
                  (SAMPLE_W+GAIN_W+1)'($signed({1'b0, fetch_env}));
    scaled      = sample_t'(product >>> FRAC_W);
  end

  assign bus.busy = (play_state != IDLE);

  sample_phase_acc #(
    .LAST_ADDR  (LAST_ADDR),
    .LOOP_START (LOOP_START)
  ) u_phase (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (bus.note_on),
    .advance  (advance),
    .step     (bus.step),
    .loop_en  (bus.loop_en),
    .int_addr (int_addr),
    .end_hit  (end_hit)
  );

  // Play state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) play_state <= IDLE;
    else          play_state <= play_next;
  end

  // Play transitions: note_on always wins, end of one-shot or empty envelope goes idle
  always_comb begin
    play_next = play_state;
    if (bus.note_on) begin
      play_next = PLAY;
    end else begin
      unique case (play_state)
        IDLE:    play_next = IDLE;
        PLAY: begin
          if (end_hit)           play_next = IDLE;
          else if (bus.note_off) play_next = RELEASE;
        end
        RELEASE: begin
          if (end_hit)                 play_next = IDLE;
          else if (upd && env <= REL)  play_next = IDLE;
        end
        default: play_next = IDLE;
      endcase
    end
  end

  // Envelope: loaded on note_on, decays by REL per sample while releasing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      env <= '0;
    end else if (bus.note_on) begin
      env <= bus.gain;
    end else if (end_hit) begin
      env <= '0;
    end else if (upd && play_state == RELEASE) begin
      env <= (env > REL) ? env - REL : '0;
    end
  end

  // Fetch state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fetch_state <= F_WAIT;
    else          fetch_state <= fetch_next;
  end

  // Fetch sequencing: address out, wait for registered ROM data, deliver
  always_comb begin
    fetch_next = fetch_state;
    unique case (fetch_state)
      F_WAIT:  if (bus.sample_req) fetch_next = F_ADDR;
      F_ADDR:  fetch_next = F_DATA;
      F_DATA:  fetch_next = F_WAIT;
      default: fetch_next = F_WAIT;
    endcase
  end

  // Fetch datapath: latch address and envelope at accept, scale and emit at delivery
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rom_addr     <= '0;
      bus.sample_out   <= '0;
      bus.sample_valid <= 1'b0;
      bus.overrun      <= 1'b0;
      fetch_env        <= '0;
      fetch_silent     <= 1'b1;
      skip_adv         <= 1'b0;
    end else begin
      bus.sample_valid <= sample_done;
      if (req_accept) begin
        bus.rom_addr <= int_addr;
        fetch_env    <= env;
        fetch_silent <= (play_state == IDLE);
      end
      if (bus.sample_req && fetch_state != F_WAIT) begin
        bus.overrun <= 1'b1;
      end
      if (sample_done) begin
        bus.sample_out <= fetch_silent ? '0 : scaled;
      end
      if (sample_done) begin
        skip_adv <= 1'b0;
      end else if (bus.note_on && (req_accept || fetch_state == F_ADDR)) begin
        skip_adv <= 1'b1;
      end
    end
  end

endmodule
